// File: rtl/sram_axi_slave_if.sv
// rtl/sram_axi_slave_if.sv - AXI3-style slave bus bundle for the SRAM bridge
interface sram_axi_slave_if;
  logic [7:0]  AWID_S;
  logic [31:0] AWADDR_S;
  logic [3:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic        WVALID_S;
  logic        WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S;

  modport slave (
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S
  );

  modport master (
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S
  );
endinterface

// File: rtl/sram_axi_slave.sv
// rtl/sram_axi_slave.sv - single-outstanding AXI slave bridging INCR bursts onto a 16K x 32 SRAM
module sram_axi_slave (
  input  logic                   clk,
  input  logic                   rstn,
  sram_axi_slave_if.slave        axi,
  output logic                   CEB,
  output logic                   WEB,
  output logic [13:0]            A,
  output logic [31:0]            DI,
  output logic [31:0]            BWEB,
  input  logic [31:0]            DO
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] R_ACC  = 3'd1;
  localparam logic [2:0] R_DATA = 3'd2;
  localparam logic [2:0] W_DATA = 3'd3;
  localparam logic [2:0] W_RESP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  id_q, id_d;
  logic [13:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        first_q, first_d;

  logic aw_hs, ar_hs, w_hs, r_hs, b_hs, last_beat;

  assign aw_hs     = (state_q == IDLE) && axi.AWVALID_S;
  assign ar_hs     = (state_q == IDLE) && !axi.AWVALID_S && axi.ARVALID_S;
  assign w_hs      = (state_q == W_DATA) && axi.WVALID_S;
  assign r_hs      = (state_q == R_DATA) && axi.RREADY_S;
  assign b_hs      = (state_q == W_RESP) && axi.BREADY_S;
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rdata_d = first_q ? DO : rdata_q;
    first_d = (state_q == R_ACC);
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = axi.AWID_S;
          addr_d  = axi.AWADDR_S[15:2];
          len_d   = axi.AWLEN_S;
          state_d = W_DATA;
        end else if (ar_hs) begin
          id_d    = axi.ARID_S;
          addr_d  = axi.ARADDR_S[15:2];
          len_d   = axi.ARLEN_S;
          cnt_d   = 4'd0;
          state_d = R_ACC;
        end
      end
      R_ACC:  state_d = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 14'd1;
            cnt_d   = cnt_q + 4'd1;
            state_d = R_ACC;
          end
        end
      end
      W_DATA: begin
        if (w_hs) begin
          addr_d = addr_q + 14'd1;
          if (axi.WLAST_S) state_d = W_RESP;
        end
      end
      W_RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      first_q <= first_d;
    end
  end

  // DO is only valid in the first R_DATA cycle; after that the captured copy holds the beat.
  assign axi.RDATA_S   = first_q ? DO : rdata_q;
  assign axi.RVALID_S  = (state_q == R_DATA);
  assign axi.RLAST_S   = (state_q == R_DATA) && last_beat;
  assign axi.RID_S     = id_q;
  assign axi.RRESP_S   = 2'b00;
  assign axi.AWREADY_S = (state_q == IDLE);
  assign axi.ARREADY_S = (state_q == IDLE) && !axi.AWVALID_S;
  assign axi.WREADY_S  = (state_q == W_DATA);
  assign axi.BVALID_S  = (state_q == W_RESP);
  assign axi.BID_S     = id_q;
  assign axi.BRESP_S   = 2'b00;

  assign CEB  = !((state_q == R_ACC) || w_hs);
  assign WEB  = !w_hs;
  assign A    = addr_q;
  assign DI   = axi.WDATA_S;
  assign BWEB = w_hs ? {{8{~axi.WSTRB_S[3]}}, {8{~axi.WSTRB_S[2]}},
                        {8{~axi.WSTRB_S[1]}}, {8{~axi.WSTRB_S[0]}}} : '1;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, axi.AWSIZE_S, axi.AWBURST_S, axi.ARSIZE_S, axi.ARBURST_S,
                           axi.AWADDR_S[31:16], axi.AWADDR_S[1:0],
                           axi.ARADDR_S[31:16], axi.ARADDR_S[1:0]};
endmodule

// File: tb/tb_sram_axi_slave.sv
// tb/tb_sram_axi_slave.sv - directed bench for sram_axi_slave with a behavioural SRAM
module tb_sram_axi_slave;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        CEB, WEB;
  logic [13:0] A;
  logic [31:0] DI, BWEB, DO;

  sram_axi_slave_if axi();

  sram_axi_slave dut (
    .clk(clk), .rstn(rstn), .axi(axi),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .BWEB(BWEB), .DO(DO)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  int n_acc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // SRAM: write masked by BWEB, read data appears on DO the cycle after the access
  always @(posedge clk) begin
    if (!CEB) begin
      n_acc <= n_acc + 1;
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
      else      DO <= mem[A];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    axi.AWID_S = id; axi.AWADDR_S = addr; axi.AWLEN_S = len;
    axi.AWSIZE_S = 3'd2; axi.AWBURST_S = 2'b01; axi.AWVALID_S = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.AWREADY_S && n < 20) begin @(negedge clk); n++; end
    check("aw_ready", {31'd0, axi.AWREADY_S}, 32'd1);
    @(posedge clk); #1;
    axi.AWVALID_S = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [13:0] exp_a, input logic [31:0] exp_bweb);
    int n;
    axi.WDATA_S = data; axi.WSTRB_S = strb; axi.WLAST_S = last; axi.WVALID_S = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.WREADY_S && n < 20) begin @(negedge clk); n++; end
    check("w_ready", {31'd0, axi.WREADY_S}, 32'd1);
    check("w_ceb", {31'd0, CEB}, 32'd0);
    check("w_web", {31'd0, WEB}, 32'd0);
    check("w_addr", {18'd0, A}, {18'd0, exp_a});
    check("w_di", DI, data);
    check("w_bweb", BWEB, exp_bweb);
    ref_mem[exp_a] = (ref_mem[exp_a] & exp_bweb) | (data & ~exp_bweb);
    @(posedge clk); #1;
    axi.WVALID_S = 1'b0; axi.WLAST_S = 1'b0;
  endtask

  task automatic b_wait(input logic [7:0] exp_id);
    int n;
    axi.BREADY_S = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.BVALID_S && n < 20) begin @(negedge clk); n++; end
    check("b_valid", {31'd0, axi.BVALID_S}, 32'd1);
    check("b_id", {24'd0, axi.BID_S}, {24'd0, exp_id});
    check("b_resp", {30'd0, axi.BRESP_S}, 32'd0);
    @(posedge clk); #1;
    axi.BREADY_S = 1'b0;
  endtask

  // Checks the two-cycle cadence per beat: access cycle (CEB=0, RVALID=0) then data cycle.
  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int stall_beat);
    int n;
    logic [13:0] wa;
    wa = addr[15:2];
    axi.ARID_S = id; axi.ARADDR_S = addr; axi.ARLEN_S = len;
    axi.ARSIZE_S = 3'd2; axi.ARBURST_S = 2'b01; axi.ARVALID_S = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.ARREADY_S && n < 40) begin @(negedge clk); n++; end
    check("ar_ready", {31'd0, axi.ARREADY_S}, 32'd1);
    @(posedge clk); #1;
    axi.ARVALID_S = 1'b0;
    for (int beat = 0; beat <= int'(len); beat++) begin
      @(negedge clk);
      check("r_acc_rvalid", {31'd0, axi.RVALID_S}, 32'd0);
      check("r_acc_ceb", {31'd0, CEB}, 32'd0);
      check("r_acc_web", {31'd0, WEB}, 32'd1);
      check("r_acc_addr", {18'd0, A}, {18'd0, wa});
      @(posedge clk); #1;
      if (beat == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("r_stall_rvalid", {31'd0, axi.RVALID_S}, 32'd1);
          check("r_stall_data", axi.RDATA_S, ref_mem[wa]);
          check("r_stall_ceb", {31'd0, CEB}, 32'd1);
          @(posedge clk); #1;
        end
      end
      axi.RREADY_S = 1'b1;
      @(negedge clk);
      check("r_valid", {31'd0, axi.RVALID_S}, 32'd1);
      check("r_data", axi.RDATA_S, ref_mem[wa]);
      check("r_last", {31'd0, axi.RLAST_S}, {31'd0, beat == int'(len)});
      check("r_id", {24'd0, axi.RID_S}, {24'd0, id});
      check("r_resp", {30'd0, axi.RRESP_S}, 32'd0);
      @(posedge clk); #1;
      axi.RREADY_S = 1'b0;
      wa = wa + 14'd1;
    end
  endtask

  int snap;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] <= 32'd0;
      ref_mem[i] = 32'd0;
    end
    axi.AWID_S = '0; axi.AWADDR_S = '0; axi.AWLEN_S = '0; axi.AWSIZE_S = '0;
    axi.AWBURST_S = '0; axi.AWVALID_S = 1'b0;
    axi.WDATA_S = '0; axi.WSTRB_S = '0; axi.WLAST_S = 1'b0; axi.WVALID_S = 1'b0;
    axi.BREADY_S = 1'b0;
    axi.ARID_S = '0; axi.ARADDR_S = '0; axi.ARLEN_S = '0; axi.ARSIZE_S = '0;
    axi.ARBURST_S = '0; axi.ARVALID_S = 1'b0; axi.RREADY_S = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bvalid", {31'd0, axi.BVALID_S}, 32'd0);
    check("rst_rvalid", {31'd0, axi.RVALID_S}, 32'd0);
    check("rst_rlast", {31'd0, axi.RLAST_S}, 32'd0);
    check("rst_wready", {31'd0, axi.WREADY_S}, 32'd0);
    check("rst_rdata", axi.RDATA_S, 32'd0);
    check("rst_rid", {24'd0, axi.RID_S}, 32'd0);
    check("rst_bid", {24'd0, axi.BID_S}, 32'd0);
    check("rst_ceb", {31'd0, CEB}, 32'd1);
    check("rst_web", {31'd0, WEB}, 32'd1);
    check("rst_bweb", BWEB, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rstn = 1'b1;

    aw_send(8'h05, 32'h10, 4'd0);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b1, 14'h0004, 32'h0000_0000);
    b_wait(8'h05);
    axi_read(8'h3C, 32'h10, 4'd0, -1);

    aw_send(8'h21, 32'hFFF8, 4'd3);
    w_send(32'h1111_0000, 4'hF, 1'b0, 14'h3FFE, 32'h0);
    w_send(32'h1111_0001, 4'hF, 1'b0, 14'h3FFF, 32'h0);
    w_send(32'h1111_0002, 4'hF, 1'b0, 14'h0000, 32'h0);
    w_send(32'h1111_0003, 4'hF, 1'b1, 14'h0001, 32'h0);
    b_wait(8'h21);
    axi_read(8'h22, 32'hFFF8, 4'd3, 1);

    aw_send(8'h07, 32'h10, 4'd0);
    w_send(32'h0000_AB00, 4'b0010, 1'b1, 14'h0004, 32'hFFFF_00FF);
    b_wait(8'h07);
    check("partial_ref", ref_mem[4], 32'hDEAD_ABEF);
    axi_read(8'h08, 32'h10, 4'd0, -1);

    axi.ARID_S = 8'h32; axi.ARADDR_S = 32'h20; axi.ARLEN_S = 4'd0; axi.ARVALID_S = 1'b1;
    axi.AWID_S = 8'h31; axi.AWADDR_S = 32'h20; axi.AWLEN_S = 4'd0; axi.AWVALID_S = 1'b1;
    @(negedge clk);
    check("coll_awready", {31'd0, axi.AWREADY_S}, 32'd1);
    check("coll_arready", {31'd0, axi.ARREADY_S}, 32'd0);
    @(posedge clk); #1;
    axi.AWVALID_S = 1'b0;
    @(negedge clk);
    check("coll_arready_wdata", {31'd0, axi.ARREADY_S}, 32'd0);
    @(posedge clk); #1;
    w_send(32'hCAFE_F00D, 4'hF, 1'b1, 14'h0008, 32'h0);
    b_wait(8'h31);
    axi_read(8'h32, 32'h20, 4'd0, -1);

    aw_send(8'h41, 32'h40, 4'd3);
    w_send(32'hA0A0_A0A0, 4'hF, 1'b0, 14'h0010, 32'h0);
    axi.WDATA_S = 32'hB1B1_B1B1; axi.WSTRB_S = 4'hF; axi.WLAST_S = 1'b0; axi.WVALID_S = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    snap = n_acc;
    check("mid_rst_ceb", {31'd0, CEB}, 32'd1);
    check("mid_rst_web", {31'd0, WEB}, 32'd1);
    check("mid_rst_bweb", BWEB, 32'hFFFF_FFFF);
    check("mid_rst_wready", {31'd0, axi.WREADY_S}, 32'd0);
    check("mid_rst_bvalid", {31'd0, axi.BVALID_S}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    axi.WVALID_S = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_no_access", n_acc, snap);
    check("post_rst_awready", {31'd0, axi.AWREADY_S}, 32'd1);
    check("post_rst_arready", {31'd0, axi.ARREADY_S}, 32'd1);
    @(posedge clk); #1;
    axi_read(8'h42, 32'h44, 4'd0, -1);
    axi_read(8'h43, 32'h40, 4'd0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_axi_slave.md
SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

Interface
REQ-001 SHALL have input clk, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have input rstn, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have inputs AWID_S[7:0], AWADDR_S[31:0], AWLEN_S[3:0], AWSIZE_S[2:0], AWBURST_S[1:0], AWVALID_S and output AWREADY_S: AXI write-address channel.
REQ-004 SHALL have inputs WDATA_S[31:0], WSTRB_S[3:0], WLAST_S, WVALID_S and output WREADY_S: AXI write-data channel.
REQ-005 SHALL have outputs BID_S[7:0], BRESP_S[1:0], BVALID_S and input BREADY_S: AXI write-response channel.
REQ-006 SHALL have inputs ARID_S[7:0], ARADDR_S[31:0], ARLEN_S[3:0], ARSIZE_S[2:0], ARBURST_S[1:0], ARVALID_S and output ARREADY_S: AXI read-address channel.
REQ-007 SHALL have outputs RID_S[7:0], RDATA_S[31:0], RRESP_S[1:0], RLAST_S, RVALID_S and input RREADY_S: AXI read-data channel.
REQ-008 SHALL have SRAM-side outputs CEB (1, active-low chip enable), WEB (1, low = write), A[13:0] (word address), DI[31:0], BWEB[31:0] (active-low bit write enable), and input DO[31:0] (read data, valid the cycle after a read access).

Function
REQ-009 SHALL implement FSM states IDLE, R_ACC, R_DATA, W_DATA, W_RESP.
REQ-010 In IDLE SHALL drive AWREADY_S=1; SHALL drive ARREADY_S=1 only when AWVALID_S=0 (write wins simultaneous requests).
REQ-011 On AW handshake SHALL latch AWID, AWADDR[15:2] and AWLEN, and go to W_DATA.
REQ-012 On AR handshake (no AW handshake) SHALL latch ARID, ARADDR[15:2] and ARLEN, clear beat counter, and go to R_ACC.
REQ-013 SHALL support INCR bursts of 1-16 beats, 4-byte size only; AxSIZE and AxBURST are not checked.
REQ-014 In R_ACC SHALL drive CEB=0, WEB=1, A=current word address for exactly one cycle, then go to R_DATA.
REQ-015 On entry to R_DATA SHALL capture DO into an RDATA register; RVALID_S=1 and RDATA_S stable until R handshake (RREADY_S backpressure holds data with CEB=1).
REQ-016 RLAST_S SHALL be 1 iff beat counter == latched LEN while RVALID_S=1; RID_S=latched ID; RRESP_S=2'b00.
REQ-017 On R handshake with RLAST_S=0 SHALL increment word address and counter and return to R_ACC; with RLAST_S=1 SHALL return to IDLE.
REQ-018 Read latency SHALL be: AR handshake in cycle T -> SRAM read in T+1 -> RVALID_S in T+2; each further beat 2 cycles after previous R handshake.
REQ-019 In W_DATA SHALL drive WREADY_S=1; on W handshake SHALL drive CEB=0, WEB=0, A=current address, DI=WDATA_S, BWEB[8i+7:8i]={8{~WSTRB_S[i]}} combinationally in that cycle, then increment the address.
REQ-020 On W handshake with WLAST_S=1 SHALL go to W_RESP; beat count mismatch vs AWLEN is not checked.
REQ-021 In W_RESP SHALL drive BVALID_S=1, BID_S=latched ID, BRESP_S=2'b00 until B handshake, then go to IDLE.
REQ-022 Word address SHALL wrap modulo 2^14 (0x3FFF + 1 -> 0x0000).
REQ-023 When no access occurs SHALL drive CEB=1, WEB=1, BWEB=all ones; A and DI don't-care.
REQ-024 Only one transaction SHALL be in flight; all READY outputs other than the one for the active state SHALL be 0.

Reset
REQ-025 On rstn=0 SHALL enter IDLE immediately; BVALID_S, RVALID_S, RLAST_S, WREADY_S=0; RDATA_S, RID_S, BID_S, counter, address=0; CEB=1, WEB=1, BWEB=all ones.
REQ-026 Reset mid-burst SHALL abort the transaction with no further SRAM writes; after release, ready for a new transaction next cycle.

Verification
REQ-027 Single write AW addr 0x10, ID 0x05, W 0xDEADBEEF strb 4'hF -> SRAM write A=4, BWEB=0; BVALID with BID 0x05, BRESP 0.
REQ-028 Single read ARADDR 0x10 after above -> RVALID at T+2, RDATA 0xDEADBEEF, RLAST=1, RID=AR ID.
REQ-029 4-beat read from 0xFFF8 with RREADY low 3 cycles on beat 2 -> A sequence 0x3FFE,0x3FFF,0x0000,0x0001; RDATA held stable; RLAST only on beat 4.
REQ-030 Partial write strb 4'b0010 data 0x0000AB00 -> BWEB=0xFFFF00FF; subsequent read returns only byte 1 changed.
REQ-031 AWVALID and ARVALID asserted same cycle -> write serviced first (ARREADY=0), read accepted in IDLE after B handshake.
REQ-032 rstn pulsed low during W_DATA beat 2 of 4 -> all outputs at reset values, no further CEB=0, new read accepted after release.
